dec_round_key_feeder: RTL
=========================

DEC_ROUND_KEY_FEEDER -- requirements
Module: dec_round_key_feeder

Interface
REQ-001 SHALL have parameter BLOCK_LENGTH, default 128, meaning the round-key width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port keys_in, input, 1408, the expanded key bank; k_i = keys_in[128*i+127:128*i], so k10 is at the MSB and k0 at the LSB.
REQ-005 SHALL have port keys_valid, input, 1, a one-cycle pulse from the FSM after key expansion completes.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse requesting round keys for one block.
REQ-007 SHALL have port rk_ready, input, 1, asserted by the inverse-round datapath when it accepts a key.
REQ-008 SHALL have port rk_data, output, 128, the current round key.
REQ-009 SHALL have port rk_valid, output, 1, asserted when rk_data is valid.
REQ-010 SHALL have port rk_round, output, 4, the index i of the key on rk_data.
REQ-011 SHALL have port rk_last, output, 1, asserted with rk_valid when rk_round==0.
REQ-012 SHALL have port bank_loaded, output, 1, asserted while a captured bank is held.
REQ-013 SHALL have port busy, output, 1, asserted in SERVE.

Function
REQ-014 SHALL implement an FSM with states IDLE, READY and SERVE.
REQ-015 In IDLE, keys_valid SHALL capture keys_in into the internal bank, and the FSM SHALL move to READY; start SHALL be ignored.
REQ-016 In READY, start SHALL move the FSM to SERVE with idx=10; rk_valid=1 and rk_data=k10 SHALL appear on the next cycle (1-cycle latency).
REQ-017 In SERVE, rk_data, rk_round and rk_valid SHALL stay stable until rk_valid&&rk_ready; each transfer SHALL decrement idx by one (order k10..k0).
REQ-018 The transfer at idx==0 SHALL return the FSM to READY; rk_valid SHALL be 0 on the next cycle, and the bank SHALL be retained for the next block.
REQ-019 In READY, simultaneous keys_valid and start SHALL capture the new bank, ignore start, and keep the FSM in READY.
REQ-020 keys_valid in SERVE SHALL store keys_in in a pending register; the bank SHALL be updated on the cycle after the final transfer; a later keys_valid SHALL overwrite the pending register.
REQ-021 start in SERVE SHALL be ignored.
REQ-022 rk_round SHALL equal idx, and SHALL never wrap below 0.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst SHALL force IDLE, bank and pending register to 0, pending flag to 0, and rk_data, rk_valid, rk_round, rk_last, bank_loaded and busy to 0 on the next edge.
REQ-025 rst during SERVE SHALL abort the sequence, with rk_valid=0 on the cycle after the rst edge.

Configuration
REQ-026 Macro DEC_EQ_INV_CIPHER_EN defined: at capture, k1..k9 SHALL be stored as InvMixColumns(k_i), while k0 and k10 are stored unchanged (FIPS-197 equivalent inverse cipher).
REQ-027 Macro DEC_EQ_INV_CIPHER_EN undefined: all keys SHALL be stored unmodified, and no InvMixColumns logic SHALL be present.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, NUM_ROUNDS=10, KEY_BANK_W=1408, and the GF(2^8) xtime constant 8'h1B.
REQ-029 One sub-module, inv_mix_columns (128-bit combinational), SHALL be instantiated per transformed key only under DEC_EQ_INV_CIPHER_EN.

Verification
REQ-030 Load the FIPS-197 C.1 bank for key 000102030405060708090a0b0c0d0e0f, start, rk_ready=1 -> 11 transfers on consecutive cycles; first rk_data=13111d7fe3944a17f307a78b4d2b30c5 with rk_round=10; last rk_data=000102030405060708090a0b0c0d0e0f with rk_round=0 and rk_last=1.
REQ-031 Same bank, rk_ready toggling 1010... -> same 11 keys in order, with rk_data stable during stalls.
REQ-032 keys_valid with a second bank at transfer 5 of SERVE -> remaining keys come from the first bank; the next start serves the second bank.
REQ-033 start in IDLE -> rk_valid stays 0; rst at transfer 3 -> rk_valid=0 next cycle and bank_loaded=0.
REQ-034 With DEC_EQ_INV_CIPHER_EN, C.1 bank -> rk_round=9 gives rk_data=13aa29be9c8faff6f770f58000f7bf03; k10 and k0 are unchanged.

Source files
------------

// File: rtl/dec_round_key_feeder_pkg.sv
// Shared types and constants for the decryption round-key feeder.
package dec_round_key_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_BANK_W = 1408;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/dec_round_key_feeder_inv_mix_columns.sv
// Combinational AES InvMixColumns on a 128-bit state, byte 0 at the MSB, column-major.
module inv_mix_columns
  import dec_round_key_feeder_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  // Multiples 9, 11, 13 and 14 are built from the 2x/4x/8x xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign dout[127-32*c -: 32] = inv_mix_col(din[127-32*c -: 32]);
  end

endmodule

// File: rtl/dec_round_key_feeder.sv
// Serves a captured AES-128 key bank as round keys k10..k0 over a valid/ready port.
// DEC_EQ_INV_CIPHER_EN stores k1..k9 as InvMixColumns(k_i) for the equivalent inverse cipher.
module dec_round_key_feeder
  import dec_round_key_feeder_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [KEY_BANK_W-1:0]   keys_in,
  input  logic                    keys_valid,
  input  logic                    start,
  input  logic                    rk_ready,
  output logic [BLOCK_LENGTH-1:0] rk_data,
  output logic                    rk_valid,
  output logic [3:0]              rk_round,
  output logic                    rk_last,
  output logic                    bank_loaded,
  output logic                    busy
);

  logic [KEY_BANK_W-1:0] cap_bank;

`ifdef DEC_EQ_INV_CIPHER_EN
  assign cap_bank[BLOCK_LENGTH-1:0]              = keys_in[BLOCK_LENGTH-1:0];
  assign cap_bank[KEY_BANK_W-1 -: BLOCK_LENGTH]  = keys_in[KEY_BANK_W-1 -: BLOCK_LENGTH];
  for (genvar i = 1; i < NUM_ROUNDS; i++) begin : g_imc
    inv_mix_columns u_imc (
      .din  (keys_in[i*BLOCK_LENGTH +: BLOCK_LENGTH]),
      .dout (cap_bank[i*BLOCK_LENGTH +: BLOCK_LENGTH])
    );
  end
`else
  assign cap_bank = keys_in;
`endif

  state_e                  state_q, state_d;
  logic [KEY_BANK_W-1:0]   bank_q, bank_d;
  logic [KEY_BANK_W-1:0]   pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [BLOCK_LENGTH-1:0] rk_data_q, rk_data_d;
  logic                    rk_valid_q, rk_valid_d;
  logic [3:0]              rk_round_q, rk_round_d;
  logic                    rk_last_q, rk_last_d;
  logic                    bank_loaded_q, bank_loaded_d;
  logic                    busy_q, busy_d;
  logic [3:0]              next_idx;

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    rk_data_d  = rk_data_q;
    rk_valid_d = rk_valid_q;
    rk_round_d = rk_round_q;
    rk_last_d  = rk_last_q;
    next_idx   = rk_round_q - 4'd1;
    case (state_q)
      ST_IDLE: begin
        if (keys_valid) begin
          bank_d  = cap_bank;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // A new bank wins over a simultaneous start.
        if (keys_valid) begin
          bank_d = cap_bank;
        end else if (start) begin
          state_d    = ST_SERVE;
          rk_valid_d = 1'b1;
          rk_round_d = 4'(NUM_ROUNDS);
          rk_last_d  = 1'b0;
          rk_data_d  = bank_q[NUM_ROUNDS*BLOCK_LENGTH +: BLOCK_LENGTH];
        end
      end
      ST_SERVE: begin
        if (keys_valid) begin
          pend_d     = cap_bank;
          pend_vld_d = 1'b1;
        end
        if (rk_valid_q && rk_ready) begin
          if (rk_round_q == 4'd0) begin
            state_d    = ST_READY;
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
            // The newest bank is applied as soon as the block is done.
            if (keys_valid) begin
              bank_d     = cap_bank;
              pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
              bank_d     = pend_q;
              pend_vld_d = 1'b0;
            end
          end else begin
            rk_round_d = next_idx;
            rk_last_d  = (next_idx == 4'd0);
            rk_data_d  = bank_q[int'(next_idx)*BLOCK_LENGTH +: BLOCK_LENGTH];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d        = (state_d == ST_SERVE);
    bank_loaded_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bank_q        <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      rk_data_q     <= '0;
      rk_valid_q    <= 1'b0;
      rk_round_q    <= 4'd0;
      rk_last_q     <= 1'b0;
      bank_loaded_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      rk_data_q     <= rk_data_d;
      rk_valid_q    <= rk_valid_d;
      rk_round_q    <= rk_round_d;
      rk_last_q     <= rk_last_d;
      bank_loaded_q <= bank_loaded_d;
      busy_q        <= busy_d;
    end
  end

  assign rk_data     = rk_data_q;
  assign rk_valid    = rk_valid_q;
  assign rk_round    = rk_round_q;
  assign rk_last     = rk_last_q;
  assign bank_loaded = bank_loaded_q;
  assign busy        = busy_q;

endmodule
